// File: rtl/interleaved_xbar_pkg.sv
// Shared types and helpers for the interleaved L2 crossbar: bank-select
// decode and the per-slave response-routing tag.
package interleaved_xbar_pkg;

  // Widest address the bank-select helper accepts.
  localparam int unsigned MAX_ADDR_W = 64;
  // Master index width carried in a response tag (up to 256 masters).
  localparam int unsigned MIDX_W     = 8;

  // One stage of the response-routing pipeline.
  typedef struct packed {
    logic              valid;
    logic [MIDX_W-1:0] midx;
  } resp_tag_t;

  // Bank index for a byte address: skip the intra-interleave offset bits,
  // then keep log2(banks) bits. Higher address bits do not affect routing.
  function automatic logic [31:0] bank_sel(
    input logic [MAX_ADDR_W-1:0] addr,
    input int unsigned           ilv_log2,
    input int unsigned           bank_log2
  );
    logic [MAX_ADDR_W-1:0] mask;
    mask = (MAX_ADDR_W'(1) << bank_log2) - MAX_ADDR_W'(1);
    return 32'((addr >> ilv_log2) & mask);
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// N-input round-robin arbiter. The priority pointer moves past the winner
// only on a completed handshake, so a stalled slave keeps the same winner.
module xbar_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          hs_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] rr_q, rr_d;

  // Winner: first requester at or after the pointer, wrapping modulo N.
  always_comb begin
    logic [IW:0] cand;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, rr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found && req_i[cand[IW-1:0]]) begin
        found                = 1'b1;
        gnt_o[cand[IW-1:0]]  = 1'b1;
        idx_o                = cand[IW-1:0];
      end
    end
  end

  // Pointer advance to winner+1 on handshake, hold otherwise.
  always_comb begin
    rr_d = rr_q;
    if (hs_i) begin
      rr_d = (idx_o == IW'(N-1)) ? '0 : idx_o + IW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/interleaved_xbar_rr.sv
// N-master x M-slave word-interleaved TCDM crossbar with per-bank
// round-robin arbitration and fixed-latency response routing.
module interleaved_xbar_rr
  import interleaved_xbar_pkg::*;
#(
  parameter int unsigned NR_MASTER_PORTS  = 4,
  parameter int unsigned NR_SLAVE_PORTS   = 8,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BE_WIDTH         = DATA_WIDTH/8,
  parameter int unsigned INTERLEAVE_BYTES = DATA_WIDTH/8,
  parameter int unsigned RESP_LAT         = 1,
  parameter int unsigned WRITE_RESP_ON    = 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        test_en_i,
  input  logic [NR_MASTER_PORTS-1:0]                  mst_req_i,
  input  logic [NR_MASTER_PORTS-1:0][ADDR_WIDTH-1:0]  mst_add_i,
  input  logic [NR_MASTER_PORTS-1:0]                  mst_wen_i,
  input  logic [NR_MASTER_PORTS-1:0][DATA_WIDTH-1:0]  mst_wdata_i,
  input  logic [NR_MASTER_PORTS-1:0][BE_WIDTH-1:0]    mst_be_i,
  output logic [NR_MASTER_PORTS-1:0]                  mst_gnt_o,
  output logic [NR_MASTER_PORTS-1:0]                  mst_r_valid_o,
  output logic [NR_MASTER_PORTS-1:0][DATA_WIDTH-1:0]  mst_r_rdata_o,
  output logic [NR_MASTER_PORTS-1:0]                  mst_r_opc_o,
  output logic [NR_SLAVE_PORTS-1:0]                   slv_req_o,
  output logic [NR_SLAVE_PORTS-1:0][ADDR_WIDTH-1:0]   slv_add_o,
  output logic [NR_SLAVE_PORTS-1:0]                   slv_wen_o,
  output logic [NR_SLAVE_PORTS-1:0][DATA_WIDTH-1:0]   slv_wdata_o,
  output logic [NR_SLAVE_PORTS-1:0][BE_WIDTH-1:0]     slv_be_o,
  input  logic [NR_SLAVE_PORTS-1:0]                   slv_gnt_i,
  input  logic [NR_SLAVE_PORTS-1:0][DATA_WIDTH-1:0]   slv_r_rdata_i,
  input  logic [NR_SLAVE_PORTS-1:0]                   slv_r_opc_i
);

  localparam int unsigned MIW      = (NR_MASTER_PORTS > 1) ? $clog2(NR_MASTER_PORTS) : 1;
  localparam int unsigned SW       = $clog2(NR_SLAVE_PORTS);
  localparam int unsigned ILV_LOG2 = $clog2(INTERLEAVE_BYTES);

  if ((NR_SLAVE_PORTS < 2) || ((NR_SLAVE_PORTS & (NR_SLAVE_PORTS - 1)) != 0)) begin : g_err_slaves
    $error("NR_SLAVE_PORTS must be a power of two >= 2");
  end
  if ((INTERLEAVE_BYTES < BE_WIDTH) || ((INTERLEAVE_BYTES & (INTERLEAVE_BYTES - 1)) != 0)) begin : g_err_ilv
    $error("INTERLEAVE_BYTES must be a power of two >= BE_WIDTH");
  end
  if ((RESP_LAT < 1) || (RESP_LAT > 4)) begin : g_err_lat
    $error("RESP_LAT must be in 1..4");
  end
  if ((NR_MASTER_PORTS < 1) || (NR_MASTER_PORTS > (1 << MIDX_W)) || (ADDR_WIDTH > MAX_ADDR_W)) begin : g_err_size
    $error("NR_MASTER_PORTS or ADDR_WIDTH out of supported range");
  end

  logic unused_test_en;
  assign unused_test_en = test_en_i;

  logic [NR_MASTER_PORTS-1:0][SW-1:0]              mst_sel;
  logic [NR_SLAVE_PORTS-1:0][NR_MASTER_PORTS-1:0]  arb_req;
  logic [NR_SLAVE_PORTS-1:0][NR_MASTER_PORTS-1:0]  arb_gnt;
  logic [NR_SLAVE_PORTS-1:0][MIW-1:0]              arb_idx;
  logic [NR_SLAVE_PORTS-1:0]                       slv_hs;

  resp_tag_t [NR_SLAVE_PORTS-1:0][RESP_LAT-1:0]    resp_q, resp_d;

  // Bank decode per master and the per-bank request vectors.
  always_comb begin
    mst_sel = '0;
    arb_req = '0;
    for (int unsigned m = 0; m < NR_MASTER_PORTS; m++) begin
      mst_sel[m] = SW'(bank_sel(MAX_ADDR_W'(mst_add_i[m]), ILV_LOG2, SW));
      for (int unsigned s = 0; s < NR_SLAVE_PORTS; s++) begin
        arb_req[s][m] = mst_req_i[m] && (mst_sel[m] == SW'(s));
      end
    end
  end

  for (genvar gs = 0; gs < NR_SLAVE_PORTS; gs++) begin : g_arb
    xbar_rr_arbiter #(
      .N (NR_MASTER_PORTS)
    ) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (arb_req[gs]),
      .hs_i   (slv_hs[gs]),
      .gnt_o  (arb_gnt[gs]),
      .idx_o  (arb_idx[gs])
    );
  end

  assign slv_hs = slv_req_o & slv_gnt_i;

  // Slave-side request and payload from the arbitration winner.
  always_comb begin
    slv_req_o   = '0;
    slv_add_o   = '0;
    slv_wen_o   = '0;
    slv_wdata_o = '0;
    slv_be_o    = '0;
    for (int unsigned s = 0; s < NR_SLAVE_PORTS; s++) begin
      slv_req_o[s] = |arb_req[s];
      for (int unsigned m = 0; m < NR_MASTER_PORTS; m++) begin
        if (arb_idx[s] == MIW'(m)) begin
          slv_add_o[s]   = mst_add_i[m];
          slv_wen_o[s]   = mst_wen_i[m];
          slv_wdata_o[s] = mst_wdata_i[m];
          slv_be_o[s]    = mst_be_i[m];
        end
      end
    end
  end

  // Master grant: winner of its selected bank, gated by that bank's grant.
  always_comb begin
    mst_gnt_o = '0;
    for (int unsigned m = 0; m < NR_MASTER_PORTS; m++) begin
      for (int unsigned s = 0; s < NR_SLAVE_PORTS; s++) begin
        if (mst_sel[m] == SW'(s)) begin
          mst_gnt_o[m] = arb_gnt[s][m] & slv_gnt_i[s];
        end
      end
    end
  end

  // Response tag pipeline: load on handshake, shift one stage per cycle.
  always_comb begin
    resp_d = '0;
    for (int unsigned s = 0; s < NR_SLAVE_PORTS; s++) begin
      resp_d[s][0].valid = slv_hs[s] & (slv_wen_o[s] | (WRITE_RESP_ON != 0));
      resp_d[s][0].midx  = MIDX_W'(arb_idx[s]);
      for (int unsigned st = 1; st < RESP_LAT; st++) begin
        resp_d[s][st] = resp_q[s][st-1];
      end
    end
  end

  // Response tag registers; reset drops anything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  // Route the last-stage tag of each bank back to its originating master.
  always_comb begin
    resp_tag_t tag;
    tag           = '0;
    mst_r_valid_o = '0;
    mst_r_rdata_o = '0;
    mst_r_opc_o   = '0;
    for (int unsigned s = 0; s < NR_SLAVE_PORTS; s++) begin
      tag = resp_q[s][RESP_LAT-1];
      for (int unsigned m = 0; m < NR_MASTER_PORTS; m++) begin
        if (tag.valid && (tag.midx == MIDX_W'(m))) begin
          mst_r_valid_o[m] = 1'b1;
          mst_r_rdata_o[m] = slv_r_rdata_i[s];
          mst_r_opc_o[m]   = slv_r_opc_i[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_interleaved_xbar_rr.sv
// Directed bench for interleaved_xbar_rr: three instances cover the default
// configuration, a 16-byte interleave / 4-bank / latency-3 no-write-response
// configuration, and a latency-2 configuration used for mid-flight reset.
module tb_interleaved_xbar_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_c_n;
  logic tst_en;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Instance A: defaults (4 masters, 8 banks, 4-byte interleave, latency 1)
  logic [3:0]        a_req, a_wen, a_gnt, a_rvalid, a_opc;
  logic [3:0][31:0]  a_add, a_wdata, a_rdata;
  logic [3:0][3:0]   a_be;
  logic [7:0]        a_sreq, a_swen, a_sgnt, a_sopc;
  logic [7:0][31:0]  a_sadd, a_swdata, a_srdata;
  logic [7:0][3:0]   a_sbe;

  // Instance B: 16-byte interleave, 4 banks, latency 3, no write response
  logic [3:0]        b_req, b_wen, b_gnt, b_rvalid, b_opc;
  logic [3:0][31:0]  b_add, b_wdata, b_rdata;
  logic [3:0][3:0]   b_be;
  logic [3:0]        b_sreq, b_swen, b_sgnt, b_sopc;
  logic [3:0][31:0]  b_sadd, b_swdata, b_srdata;
  logic [3:0][3:0]   b_sbe;

  // Instance C: latency 2
  logic [3:0]        c_req, c_wen, c_gnt, c_rvalid, c_opc;
  logic [3:0][31:0]  c_add, c_wdata, c_rdata;
  logic [3:0][3:0]   c_be;
  logic [7:0]        c_sreq, c_swen, c_sgnt, c_sopc;
  logic [7:0][31:0]  c_sadd, c_swdata, c_srdata;
  logic [7:0][3:0]   c_sbe;

  interleaved_xbar_rr dut_a (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(tst_en),
    .mst_req_i(a_req), .mst_add_i(a_add), .mst_wen_i(a_wen), .mst_wdata_i(a_wdata), .mst_be_i(a_be),
    .mst_gnt_o(a_gnt), .mst_r_valid_o(a_rvalid), .mst_r_rdata_o(a_rdata), .mst_r_opc_o(a_opc),
    .slv_req_o(a_sreq), .slv_add_o(a_sadd), .slv_wen_o(a_swen), .slv_wdata_o(a_swdata), .slv_be_o(a_sbe),
    .slv_gnt_i(a_sgnt), .slv_r_rdata_i(a_srdata), .slv_r_opc_i(a_sopc)
  );

  interleaved_xbar_rr #(
    .NR_SLAVE_PORTS(4), .INTERLEAVE_BYTES(16), .RESP_LAT(3), .WRITE_RESP_ON(0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(tst_en),
    .mst_req_i(b_req), .mst_add_i(b_add), .mst_wen_i(b_wen), .mst_wdata_i(b_wdata), .mst_be_i(b_be),
    .mst_gnt_o(b_gnt), .mst_r_valid_o(b_rvalid), .mst_r_rdata_o(b_rdata), .mst_r_opc_o(b_opc),
    .slv_req_o(b_sreq), .slv_add_o(b_sadd), .slv_wen_o(b_swen), .slv_wdata_o(b_swdata), .slv_be_o(b_sbe),
    .slv_gnt_i(b_sgnt), .slv_r_rdata_i(b_srdata), .slv_r_opc_i(b_sopc)
  );

  interleaved_xbar_rr #(
    .RESP_LAT(2)
  ) dut_c (
    .clk_i(clk), .rst_ni(rst_c_n), .test_en_i(tst_en),
    .mst_req_i(c_req), .mst_add_i(c_add), .mst_wen_i(c_wen), .mst_wdata_i(c_wdata), .mst_be_i(c_be),
    .mst_gnt_o(c_gnt), .mst_r_valid_o(c_rvalid), .mst_r_rdata_o(c_rdata), .mst_r_opc_o(c_opc),
    .slv_req_o(c_sreq), .slv_add_o(c_sadd), .slv_wen_o(c_swen), .slv_wdata_o(c_swdata), .slv_be_o(c_sbe),
    .slv_gnt_i(c_sgnt), .slv_r_rdata_i(c_srdata), .slv_r_opc_i(c_sopc)
  );

  task automatic test_reset();
    rst_n = 1'b0; rst_c_n = 1'b0; tst_en = 1'b0;
    a_req = '0; a_add = '0; a_wen = '1; a_wdata = '0; a_be = '1; a_sgnt = '0;
    b_req = '0; b_add = '0; b_wen = '1; b_wdata = '0; b_be = '1; b_sgnt = '0;
    c_req = '0; c_add = '0; c_wen = '1; c_wdata = '0; c_be = '1; c_sgnt = '0;
    for (int s = 0; s < 8; s++) begin
      a_srdata[s] = 32'hDEADBEE0 + 32'(s + 10);
      c_srdata[s] = 32'h12340000 + 32'(s);
    end
    for (int s = 0; s < 4; s++) b_srdata[s] = 32'hCAFE0000 + 32'(s);
    a_sopc = 8'b0010_0000; b_sopc = '0; c_sopc = '0;
    @(negedge clk);
    a_req = 4'b0001; a_add[0] = 32'h1C000014;
    #1;
    n_checks++; if (a_sreq !== 8'h20) begin n_fail++; $display("FAIL rst_sreq got=%h exp=%h", a_sreq, 8'h20); end
    n_checks++; if (a_gnt !== 4'h0) begin n_fail++; $display("FAIL rst_gnt got=%h exp=%h", a_gnt, 4'h0); end
    n_checks++; if (a_rvalid !== 4'h0) begin n_fail++; $display("FAIL rst_rvalid_a got=%h exp=0", a_rvalid); end
    n_checks++; if (a_rdata !== '0) begin n_fail++; $display("FAIL rst_rdata_a got=%h exp=0", a_rdata); end
    n_checks++; if (a_opc !== 4'h0) begin n_fail++; $display("FAIL rst_opc_a got=%h exp=0", a_opc); end
    n_checks++; if ({b_rvalid, c_rvalid} !== 8'h00) begin n_fail++; $display("FAIL rst_rvalid_bc got=%h exp=0", {b_rvalid, c_rvalid}); end
    @(negedge clk);
    a_req = '0; a_sgnt = '1; b_sgnt = '1; c_sgnt = '1;
    rst_n = 1'b1; rst_c_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    a_req = 4'b0001; a_add[0] = 32'h1C000014; a_wen[0] = 1'b1;
    #1;
    n_checks++; if (a_sreq !== 8'h20) begin n_fail++; $display("FAIL sr_sreq got=%h exp=%h", a_sreq, 8'h20); end
    n_checks++; if (a_gnt !== 4'h1) begin n_fail++; $display("FAIL sr_gnt got=%h exp=%h", a_gnt, 4'h1); end
    n_checks++; if (a_sadd[5] !== 32'h1C000014) begin n_fail++; $display("FAIL sr_sadd got=%h exp=%h", a_sadd[5], 32'h1C000014); end
    n_checks++; if (a_swen[5] !== 1'b1) begin n_fail++; $display("FAIL sr_swen got=%b exp=1", a_swen[5]); end
    n_checks++; if (a_rvalid !== 4'h0) begin n_fail++; $display("FAIL sr_rvalid0 got=%h exp=0", a_rvalid); end
    @(negedge clk);
    a_req = '0;
    #1;
    n_checks++; if (a_rvalid !== 4'h1) begin n_fail++; $display("FAIL sr_rvalid1 got=%h exp=1", a_rvalid); end
    n_checks++; if (a_rdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sr_rdata got=%h exp=DEADBEEF", a_rdata[0]); end
    n_checks++; if (a_opc !== 4'h1) begin n_fail++; $display("FAIL sr_opc got=%h exp=1", a_opc); end
    n_checks++; if (a_rdata[1] !== 32'h0) begin n_fail++; $display("FAIL sr_rdata_idle got=%h exp=0", a_rdata[1]); end
    @(negedge clk);
    #1;
    n_checks++; if (a_rvalid !== 4'h0) begin n_fail++; $display("FAIL sr_rvalid2 got=%h exp=0", a_rvalid); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_g, exp_v;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        for (int m = 0; m < 4; m++) begin
          a_req[m] = 1'b1; a_wen[m] = 1'b1;
          a_add[m] = 32'h08 + 32'(m) * 32'h20;
          a_wdata[m] = 32'h11111111 * 32'(m + 1);
        end
      end
      #1;
      exp_g = 4'b0001 << (k % 4);
      exp_v = (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4));
      n_checks++; if (a_gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt k=%0d got=%h exp=%h", k, a_gnt, exp_g); end
      n_checks++; if (a_sadd[2] !== 32'h08 + 32'(k % 4) * 32'h20) begin n_fail++; $display("FAIL rr_sadd k=%0d got=%h exp=%h", k, a_sadd[2], 32'h08 + 32'(k % 4) * 32'h20); end
      n_checks++; if (a_swdata[2] !== 32'h11111111 * 32'((k % 4) + 1)) begin n_fail++; $display("FAIL rr_swdata k=%0d got=%h exp=%h", k, a_swdata[2], 32'h11111111 * 32'((k % 4) + 1)); end
      n_checks++; if (a_rvalid !== exp_v) begin n_fail++; $display("FAIL rr_rvalid k=%0d got=%h exp=%h", k, a_rvalid, exp_v); end
      if (k > 0) begin
        n_checks++; if (a_rdata[(k - 1) % 4] !== 32'hDEADBEEC) begin n_fail++; $display("FAIL rr_rdata k=%0d got=%h exp=DEADBEEC", k, a_rdata[(k - 1) % 4]); end
      end
    end
    @(negedge clk);
    a_req = '0;
    #1;
    n_checks++; if (a_rvalid !== 4'b1000) begin n_fail++; $display("FAIL rr_rvalid_last got=%h exp=8", a_rvalid); end
    n_checks++; if (a_opc !== 4'h0) begin n_fail++; $display("FAIL rr_opc got=%h exp=0", a_opc); end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        a_sgnt[0] = 1'b0; a_req = 4'b1010; a_wen = '1;
        a_add[1] = 32'h00; a_add[3] = 32'h20;
      end
      #1;
      n_checks++; if (a_gnt !== 4'h0) begin n_fail++; $display("FAIL st_gnt c=%0d got=%h exp=0", c, a_gnt); end
      n_checks++; if (a_sreq !== 8'h01) begin n_fail++; $display("FAIL st_sreq c=%0d got=%h exp=01", c, a_sreq); end
      n_checks++; if (a_sadd[0] !== 32'h00) begin n_fail++; $display("FAIL st_sadd c=%0d got=%h exp=0", c, a_sadd[0]); end
      n_checks++; if (a_rvalid !== 4'h0) begin n_fail++; $display("FAIL st_rvalid c=%0d got=%h exp=0", c, a_rvalid); end
    end
    @(negedge clk);
    a_sgnt[0] = 1'b1;
    #1;
    n_checks++; if (a_gnt !== 4'b0010) begin n_fail++; $display("FAIL st_gnt_m1 got=%h exp=2", a_gnt); end
    @(negedge clk);
    #1;
    n_checks++; if (a_gnt !== 4'b1000) begin n_fail++; $display("FAIL st_gnt_m3 got=%h exp=8", a_gnt); end
    n_checks++; if (a_sadd[0] !== 32'h20) begin n_fail++; $display("FAIL st_sadd_m3 got=%h exp=20", a_sadd[0]); end
    n_checks++; if (a_rvalid !== 4'b0010) begin n_fail++; $display("FAIL st_rvalid_m1 got=%h exp=2", a_rvalid); end
    n_checks++; if (a_rdata[1] !== 32'hDEADBEEA) begin n_fail++; $display("FAIL st_rdata_m1 got=%h exp=DEADBEEA", a_rdata[1]); end
    @(negedge clk);
    a_req = '0;
    #1;
    n_checks++; if (a_rvalid !== 4'b1000) begin n_fail++; $display("FAIL st_rvalid_m3 got=%h exp=8", a_rvalid); end
  endtask

  task automatic test_interleave();
    @(negedge clk);
    b_req = 4'b0111; b_wen = '1;
    b_add[0] = 32'h30; b_add[1] = 32'h40; b_add[2] = 32'h2C;
    #1;
    n_checks++; if (b_sreq !== 4'b1101) begin n_fail++; $display("FAIL il_sreq got=%h exp=D", b_sreq); end
    n_checks++; if (b_gnt !== 4'b0111) begin n_fail++; $display("FAIL il_gnt got=%h exp=7", b_gnt); end
    n_checks++; if (b_sadd[3] !== 32'h30) begin n_fail++; $display("FAIL il_sadd3 got=%h exp=30", b_sadd[3]); end
    n_checks++; if (b_sadd[0] !== 32'h40) begin n_fail++; $display("FAIL il_sadd0 got=%h exp=40", b_sadd[0]); end
    n_checks++; if (b_sadd[2] !== 32'h2C) begin n_fail++; $display("FAIL il_sadd2 got=%h exp=2C", b_sadd[2]); end
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      b_req = '0;
      #1;
      n_checks++; if (b_rvalid !== ((t == 3) ? 4'b0111 : 4'b0000)) begin n_fail++; $display("FAIL il_rvalid t=%0d got=%h exp=%h", t, b_rvalid, (t == 3) ? 4'b0111 : 4'b0000); end
      if (t == 3) begin
        n_checks++; if (b_rdata[0] !== 32'hCAFE0003) begin n_fail++; $display("FAIL il_rdata0 got=%h exp=CAFE0003", b_rdata[0]); end
        n_checks++; if (b_rdata[1] !== 32'hCAFE0000) begin n_fail++; $display("FAIL il_rdata1 got=%h exp=CAFE0000", b_rdata[1]); end
        n_checks++; if (b_rdata[2] !== 32'hCAFE0002) begin n_fail++; $display("FAIL il_rdata2 got=%h exp=CAFE0002", b_rdata[2]); end
      end
    end
  endtask

  task automatic test_latency_write();
    @(negedge clk);
    b_req = 4'b0100; b_add[2] = 32'h10; b_wen[2] = 1'b0; b_be[2] = 4'b0101; b_wdata[2] = 32'hA5A50001;
    #1;
    n_checks++; if (b_gnt !== 4'b0100) begin n_fail++; $display("FAIL lw_gnt_wr got=%h exp=4", b_gnt); end
    n_checks++; if (b_sreq !== 4'b0010) begin n_fail++; $display("FAIL lw_sreq got=%h exp=2", b_sreq); end
    n_checks++; if (b_swen[1] !== 1'b0) begin n_fail++; $display("FAIL lw_swen_wr got=%b exp=0", b_swen[1]); end
    n_checks++; if (b_sbe[1] !== 4'b0101) begin n_fail++; $display("FAIL lw_sbe got=%h exp=5", b_sbe[1]); end
    n_checks++; if (b_swdata[1] !== 32'hA5A50001) begin n_fail++; $display("FAIL lw_swdata got=%h exp=A5A50001", b_swdata[1]); end
    @(negedge clk);
    b_add[2] = 32'h14; b_wen[2] = 1'b1;
    #1;
    n_checks++; if (b_gnt !== 4'b0100) begin n_fail++; $display("FAIL lw_gnt_rd got=%h exp=4", b_gnt); end
    n_checks++; if (b_swen[1] !== 1'b1) begin n_fail++; $display("FAIL lw_swen_rd got=%b exp=1", b_swen[1]); end
    for (int t = 2; t <= 5; t++) begin
      @(negedge clk);
      b_req = '0;
      #1;
      n_checks++; if (b_rvalid !== ((t == 4) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL lw_rvalid t=%0d got=%h exp=%h", t, b_rvalid, (t == 4) ? 4'b0100 : 4'b0000); end
      n_checks++; if (b_rdata[2] !== ((t == 4) ? 32'hCAFE0001 : 32'h0)) begin n_fail++; $display("FAIL lw_rdata t=%0d got=%h exp=%h", t, b_rdata[2], (t == 4) ? 32'hCAFE0001 : 32'h0); end
    end
  endtask

  task automatic test_reset_midflight();
    // Move bank 3's pointer away from zero with a completed read by M2.
    @(negedge clk);
    c_req = 4'b0100; c_add[2] = 32'h0C; c_wen = '1;
    #1;
    n_checks++; if (c_gnt !== 4'b0100) begin n_fail++; $display("FAIL rm_gnt_m2 got=%h exp=4", c_gnt); end
    @(negedge clk);
    c_req = '0;
    #1;
    n_checks++; if (c_rvalid !== 4'h0) begin n_fail++; $display("FAIL rm_rvalid_early got=%h exp=0", c_rvalid); end
    @(negedge clk);
    #1;
    n_checks++; if (c_rvalid !== 4'b0100) begin n_fail++; $display("FAIL rm_rvalid_m2 got=%h exp=4", c_rvalid); end
    n_checks++; if (c_rdata[2] !== 32'h12340003) begin n_fail++; $display("FAIL rm_rdata_m2 got=%h exp=12340003", c_rdata[2]); end
    @(negedge clk);
    c_req = 4'b0010; c_add[1] = 32'h2C;
    #1;
    n_checks++; if (c_gnt !== 4'b0010) begin n_fail++; $display("FAIL rm_gnt_m1 got=%h exp=2", c_gnt); end
    // Reset one cycle after the M1 grant, with its response still in flight.
    @(negedge clk);
    rst_c_n = 1'b0; c_req = 4'b1000; c_add[3] = 32'h0C; c_sgnt[3] = 1'b0;
    #1;
    n_checks++; if (c_rvalid !== 4'h0) begin n_fail++; $display("FAIL rm_rvalid_rst got=%h exp=0", c_rvalid); end
    n_checks++; if (c_sreq !== 8'h08) begin n_fail++; $display("FAIL rm_sreq_rst got=%h exp=08", c_sreq); end
    n_checks++; if (c_gnt !== 4'h0) begin n_fail++; $display("FAIL rm_gnt_rst got=%h exp=0", c_gnt); end
    @(negedge clk);
    c_req = '0; c_sgnt[3] = 1'b1;
    #1;
    n_checks++; if (c_rvalid !== 4'h0) begin n_fail++; $display("FAIL rm_rvalid_drop got=%h exp=0", c_rvalid); end
    rst_c_n = 1'b1;
    @(negedge clk);
    c_req = 4'b1111;
    c_add[0] = 32'h0C; c_add[1] = 32'h2C; c_add[2] = 32'h4C; c_add[3] = 32'h6C;
    #1;
    n_checks++; if (c_gnt !== 4'b0001) begin n_fail++; $display("FAIL rm_gnt_after got=%h exp=1", c_gnt); end
    n_checks++; if (c_rvalid !== 4'h0) begin n_fail++; $display("FAIL rm_rvalid_after got=%h exp=0", c_rvalid); end
    @(negedge clk);
    c_req = '0;
    #1;
    n_checks++; if (c_rvalid !== 4'h0) begin n_fail++; $display("FAIL rm_rvalid_lat got=%h exp=0", c_rvalid); end
    @(negedge clk);
    #1;
    n_checks++; if (c_rvalid !== 4'b0001) begin n_fail++; $display("FAIL rm_rvalid_m0 got=%h exp=1", c_rvalid); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_stall();
    test_interleave();
    test_latency_write();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interleaved_xbar_rr.md
Name: interleaved_xbar_rr

Overview:
Parametrised N-master × M-slave TCDM crossbar for the SoC L2 interleaved region, with word-interleaved address mapping and configurable interleave granularity, data width and fixed response latency.
- Per-slave round-robin arbiter, so requests never starve.
- Per-slave response-routing pipeline that returns read data and write acknowledges to the originating master.
- Sits between the L2 demux master ports and the interleaved L2 banks, using flat signal arrays.

Parameters:
NR_MASTER_PORTS, 4, number of initiator ports (>=1)
NR_SLAVE_PORTS, 8, number of banks; power of two, >=2
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; power of two, >=8
BE_WIDTH, DATA_WIDTH/8, byte-enable width
INTERLEAVE_BYTES, DATA_WIDTH/8, bytes mapped to one bank before stepping to the next; power of two, >=BE_WIDTH
RESP_LAT, 1, cycles from slave grant to response; range 1..4
WRITE_RESP_ON, 1, 1 means writes also produce r_valid

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
test_en_i  in  1  test mode; no functional effect
mst_req_i  in  [NR_MASTER_PORTS]  request
mst_add_i  in  [NR_MASTER_PORTS][ADDR_WIDTH]  byte address
mst_wen_i  in  [NR_MASTER_PORTS]  1=read, 0=write
mst_wdata_i  in  [NR_MASTER_PORTS][DATA_WIDTH]  write data
mst_be_i  in  [NR_MASTER_PORTS][BE_WIDTH]  byte enables
mst_gnt_o  out  [NR_MASTER_PORTS]  grant
mst_r_valid_o  out  [NR_MASTER_PORTS]  response valid
mst_r_rdata_o  out  [NR_MASTER_PORTS][DATA_WIDTH]  read data
mst_r_opc_o  out  [NR_MASTER_PORTS]  response error flag
slv_req_o  out  [NR_SLAVE_PORTS]  request
slv_add_o  out  [NR_SLAVE_PORTS][ADDR_WIDTH]  full byte address, passed unmodified
slv_wen_o  out  [NR_SLAVE_PORTS]  1=read, 0=write
slv_wdata_o  out  [NR_SLAVE_PORTS][DATA_WIDTH]  write data
slv_be_o  out  [NR_SLAVE_PORTS][BE_WIDTH]  byte enables
slv_gnt_i  in  [NR_SLAVE_PORTS]  grant
slv_r_rdata_i  in  [NR_SLAVE_PORTS][DATA_WIDTH]  read data, valid exactly RESP_LAT cycles after handshake
slv_r_opc_i  in  [NR_SLAVE_PORTS]  error flag, same timing as rdata

Behaviour:
- Bank select:
  - sel = add[$clog2(INTERLEAVE_BYTES)+$clog2(NR_SLAVE_PORTS)-1 : $clog2(INTERLEAVE_BYTES)].
  - Remaining address bits are ignored for routing.
- Request path: combinational master to slave.
  - slv_req_o[s] = OR over masters with req=1 and sel=s.
  - Payload (add/wen/wdata/be) comes from the master that the arbiter selects for that slave.
- Arbitration: one round-robin arbiter per slave.
  - Registered priority pointer rr_q[s] ($clog2(NR_MASTER_PORTS) bits, reset 0).
  - Winner = first requesting master at or after rr_q[s], wrapping modulo NR_MASTER_PORTS.
  - mst_gnt_o[m] = 1 only when m is the winner for its selected slave AND slv_gnt_i[sel] = 1.
  - rr_q[s] updates to winner+1 (mod N) only on a handshake, i.e. slv_req_o & slv_gnt_i.
  - Without a handshake the pointer holds, so the same winner is retained while the slave stalls.
  - A master targets exactly one slave per cycle, so it receives at most one grant per cycle.
- Response routing: per slave, a RESP_LAT-deep shift register of {valid, master_idx}.
  - Stage 0 is loaded on handshake; valid = wen | WRITE_RESP_ON.
  - Output stage s: if valid, mst_r_valid_o[idx] = 1 and mst_r_rdata_o[idx]/mst_r_opc_o[idx] = slv_r_rdata_i[s]/slv_r_opc_i[s].
  - A master receives at most one response per cycle, because grants are one per master per cycle and latency is uniform.
  - Masters with no response in a cycle drive rdata = 0 and opc = 0.
- Throughput: back-to-back handshakes on every slave every cycle; no bubbles.
- Reset:
  - All rr_q and pipeline stages clear asynchronously.
  - Outputs at reset: mst_gnt_o = 0 when slv_gnt_i = 0, mst_r_valid_o = 0, mst_r_rdata_o = 0, mst_r_opc_o = 0.
  - slv_req_o follows mst_req_i combinationally.
- Reset mid-operation: in-flight responses are discarded and no r_valid is issued for them.
- Latency: grant is in the same cycle as the request; r_valid is RESP_LAT cycles after the grant.
- Invariant for the bench: for each master, #gnt − #r_valid equals in-flight count, which is <= RESP_LAT.
- Elaboration errors:
  - NR_SLAVE_PORTS not a power of two.
  - INTERLEAVE_BYTES < BE_WIDTH.
  - RESP_LAT outside 1..4.

Decomposition:
- Package interleaved_xbar_pkg: bank-select function (address → index given INTERLEAVE_BYTES and NR_SLAVE_PORTS) and the response-tag struct {valid, master_idx}.
- Sub-module xbar_rr_arbiter: N-input round-robin arbiter with pointer register, inputs req/handshake, outputs one-hot grant and index. Instantiated once per slave.

Test Plan:
1. Single read, defaults: M0 reads 0x1C000014 (bank 5), slv_gnt=1 -> slv_req_o[5]=1, mst_gnt_o[0] same cycle; next cycle mst_r_valid_o[0]=1, rdata=0xDEADBEEF as driven by bank 5.
2. Contention: M0..M3 all read bank 2 continuously, slv_gnt=1 -> grants rotate 0,1,2,3,0; each master receives exactly one r_valid per 4 cycles.
3. Stall: M1 and M3 request bank 0 with slv_gnt_i[0]=0 for 3 cycles -> no mst_gnt_o and rr_q held; on gnt=1, M1 is granted, then M3 next cycle.
4. Interleave granularity: INTERLEAVE_BYTES=16, NR_SLAVE_PORTS=4, address 0x30 -> bank 3; address 0x40 -> bank 0.
5. Latency and writes: RESP_LAT=3, WRITE_RESP_ON=0, M2 writes then reads bank 1 on consecutive cycles -> a single r_valid[2], 3 cycles after the read grant.
6. Reset mid-flight: RESP_LAT=2, assert rst_ni low one cycle after a grant -> no r_valid ever emitted; after release, M0 is granted first again (rr_q=0).
